llc_input_scheduler: RTL and testbench

LLC_INPUT_SCHEDULER -- requirements
Module: llc_input_scheduler

---
 rtl/llc_input_scheduler_pkg.sv | 30 +++
 rtl/llc_input_scheduler_if.sv | 36 +++
 rtl/llc_decision_fifo.sv | 54 +++++
 rtl/llc_input_scheduler.sv | 147 ++++++++++++++
 tb/tb_llc_input_scheduler.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/llc_input_scheduler_pkg.sv
// Shared types and address geometry for the LLC input scheduler.
// Line address splits into {tag, set}; queue entries record the winning source.
package llc_input_scheduler_pkg;

    localparam int LLC_SET_BITS   = 8;
    localparam int LLC_TAG_BITS   = 8;
    localparam int LINE_ADDR_BITS = LLC_TAG_BITS + LLC_SET_BITS;
    localparam int CH_ID_BITS     = 3;

    typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;

    typedef struct packed {
        logic                  is_resume;
        logic [CH_ID_BITS-1:0] ch;
        line_addr_t            addr;
    } sched_entry_t;

    function automatic logic [LLC_SET_BITS-1:0] addr_set(
        input line_addr_t a
    );
        return a[LLC_SET_BITS-1:0];
    endfunction

    function automatic logic [LLC_TAG_BITS-1:0] addr_tag(
        input line_addr_t a
    );
        return a[LINE_ADDR_BITS-1:LLC_SET_BITS];
    endfunction

endpackage

// File: rtl/llc_input_scheduler_if.sv
// Request-side bundle between the input channels and the scheduler.
// Requesters drive valid/stall/addr; the scheduler answers with get pulses.
interface llc_input_scheduler_if #(
    parameter int NUM_CH = 4
);
    import llc_input_scheduler_pkg::*;

    logic [NUM_CH-1:0] ch_valid;
    logic [NUM_CH-1:0] ch_stall;
    line_addr_t [NUM_CH-1:0] ch_addr;
    logic [NUM_CH-1:0] ch_get;
    logic              resume_valid;
    line_addr_t        resume_addr;
    logic              resume_get;

    modport master (
        output ch_valid,
        output ch_stall,
        output ch_addr,
        output resume_valid,
        output resume_addr,
        input  ch_get,
        input  resume_get
    );

    modport slave (
        input  ch_valid,
        input  ch_stall,
        input  ch_addr,
        input  resume_valid,
        input  resume_addr,
        output ch_get,
        output resume_get
    );

endinterface

// File: rtl/llc_decision_fifo.sv
// Circular decision queue; the head is only visible once written,
// so a push into an empty queue cannot be popped in the same cycle.
module llc_decision_fifo
    import llc_input_scheduler_pkg::*;
#(
    parameter int  QDEPTH  = 4,
    parameter type entry_t = sched_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  entry_t push_data,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int PW = $clog2(QDEPTH);

    entry_t        mem [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (PW+1)'(QDEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/llc_input_scheduler.sv
// Picks one request per cycle (resume, then ch0, then fixed/RR among the rest),
// queues the decision and presents the popped head as registered set/tag.
module llc_input_scheduler
    import llc_input_scheduler_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int QDEPTH = 4,
    parameter int RR_EN  = 0,
    parameter int RSP_CH = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    llc_input_scheduler_if.slave        req,
    input  logic                        decode_en,
    input  logic                        rd_set_en,
    input  logic [LLC_SET_BITS-1:0]     stalled_set,
    input  logic [LLC_TAG_BITS-1:0]     stalled_tag,
    input  logic                        req_stall,
    output logic                        out_valid,
    output logic                        out_is_resume,
    output logic [$clog2(NUM_CH)-1:0]   out_ch,
    output logic [LLC_SET_BITS-1:0]     out_set,
    output logic [LLC_TAG_BITS-1:0]     out_tag,
    output logic [LLC_SET_BITS-1:0]     set_next,
    output logic                        clr_req_stall,
    output logic                        idle,
    output logic                        q_full,
    output logic                        q_empty
);

    localparam int CW = $clog2(NUM_CH);

    logic [NUM_CH-1:0] elig;
    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     rr_win;
    logic [CW-1:0]     fp_win;
    logic [CW-1:0]     win_ch;
    logic              any_src;
    logic              push_ok;
    logic              grant;
    logic              pop;
    int                rr_i;
    sched_entry_t      push_e;
    sched_entry_t      head;

    assign elig    = req.ch_valid & ~req.ch_stall;
    assign any_src = req.resume_valid || (|elig);
    assign push_ok = !q_full || rd_set_en;
    assign grant   = rst && decode_en && push_ok && any_src;
    assign pop     = rd_set_en && !q_empty;

    // Descending scans: the last hit written is the highest-priority one.
    always_comb begin
        fp_win = '0;
        rr_win = '0;
        rr_i   = 0;
        for (int i = NUM_CH - 1; i >= 1; i--) begin
            if (elig[i]) fp_win = CW'(i);
        end
        for (int k = NUM_CH - 2; k >= 0; k--) begin
            rr_i = 1 + ((int'(rr_ptr) - 1 + k) % (NUM_CH - 1));
            if (elig[rr_i]) rr_win = CW'(rr_i);
        end
    end

    always_comb begin
        win_ch = '0;
        if (!elig[0]) win_ch = (RR_EN != 0) ? rr_win : fp_win;
    end

    always_comb begin
        req.ch_get = '0;
        if (grant && !req.resume_valid) req.ch_get[win_ch] = 1'b1;
    end

    assign req.resume_get = grant && req.resume_valid;

    always_comb begin
        push_e.is_resume = req.resume_valid;
        push_e.ch        = '0;
        push_e.addr      = req.resume_addr;
        if (!req.resume_valid) begin
            push_e.ch   = CH_ID_BITS'(win_ch);
            push_e.addr = req.ch_addr[win_ch];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= CW'(1);
        end else if (RR_EN != 0 && grant && !req.resume_valid
                     && !elig[0]) begin
            rr_ptr <= (win_ch == CW'(NUM_CH - 1)) ? CW'(1)
                                                  : win_ch + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle <= 1'b0;
        end else if (decode_en && !any_src) begin
            idle <= 1'b1;
        end else if (grant) begin
            idle <= 1'b0;
        end
    end

    llc_decision_fifo #(
        .QDEPTH  (QDEPTH),
        .entry_t (sched_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .pop       (rd_set_en),
        .push_data (push_e),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            out_is_resume <= 1'b0;
            out_ch        <= '0;
            out_set       <= '0;
            out_tag       <= '0;
        end else if (rd_set_en) begin
            out_valid <= !q_empty;
            if (!q_empty) begin
                out_is_resume <= head.is_resume;
                out_ch        <= head.ch[CW-1:0];
                out_set       <= addr_set(head.addr);
                out_tag       <= addr_tag(head.addr);
            end
        end
    end

    assign set_next = addr_set(head.addr);

    assign clr_req_stall = pop && req_stall && !head.is_resume
                        && (head.ch == CH_ID_BITS'(RSP_CH))
                        && (addr_set(head.addr) == stalled_set)
                        && (addr_tag(head.addr) == stalled_tag);

endmodule

// File: tb/tb_llc_input_scheduler.sv
// Directed bench: a fixed-priority and a round-robin scheduler
// share one stimulus stream and are checked against hand-computed values.
module tb_llc_input_scheduler;
    import llc_input_scheduler_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic                    decode_en;
    logic                    rd_set_en;
    logic                    req_stall;
    logic [N-1:0]            ch_valid;
    logic [N-1:0]            ch_stall;
    line_addr_t [N-1:0]      ch_addr;
    logic                    resume_valid;
    line_addr_t              resume_addr;
    logic [LLC_SET_BITS-1:0] stalled_set;
    logic [LLC_TAG_BITS-1:0] stalled_tag;

    int checks = 0;
    int failures = 0;

    llc_input_scheduler_if #(.NUM_CH(N)) fp_if ();
    llc_input_scheduler_if #(.NUM_CH(N)) rr_if ();

    assign fp_if.ch_valid     = ch_valid;
    assign fp_if.ch_stall     = ch_stall;
    assign fp_if.ch_addr      = ch_addr;
    assign fp_if.resume_valid = resume_valid;
    assign fp_if.resume_addr  = resume_addr;
    assign rr_if.ch_valid     = ch_valid;
    assign rr_if.ch_stall     = ch_stall;
    assign rr_if.ch_addr      = ch_addr;
    assign rr_if.resume_valid = resume_valid;
    assign rr_if.resume_addr  = resume_addr;

    logic       f_ov, f_ir, f_clr, f_idle, f_full, f_empty;
    logic [1:0] f_ch;
    logic [7:0] f_set, f_tag, f_nxt;
    logic       r_ov, r_ir, r_clr, r_idle, r_full, r_empty;
    logic [1:0] r_ch;
    logic [7:0] r_set, r_tag, r_nxt;

    llc_input_scheduler #(
        .NUM_CH(N), .QDEPTH(4), .RR_EN(0), .RSP_CH(1)
    ) u_fp (
        .clk(clk), .rst(rst), .req(fp_if),
        .decode_en(decode_en), .rd_set_en(rd_set_en),
        .stalled_set(stalled_set), .stalled_tag(stalled_tag),
        .req_stall(req_stall),
        .out_valid(f_ov), .out_is_resume(f_ir), .out_ch(f_ch),
        .out_set(f_set), .out_tag(f_tag), .set_next(f_nxt),
        .clr_req_stall(f_clr), .idle(f_idle),
        .q_full(f_full), .q_empty(f_empty)
    );

    llc_input_scheduler #(
        .NUM_CH(N), .QDEPTH(4), .RR_EN(1), .RSP_CH(1)
    ) u_rr (
        .clk(clk), .rst(rst), .req(rr_if),
        .decode_en(decode_en), .rd_set_en(rd_set_en),
        .stalled_set(stalled_set), .stalled_tag(stalled_tag),
        .req_stall(req_stall),
        .out_valid(r_ov), .out_is_resume(r_ir), .out_ch(r_ch),
        .out_set(r_set), .out_tag(r_tag), .set_next(r_nxt),
        .clr_req_stall(r_clr), .idle(r_idle),
        .q_full(r_full), .q_empty(r_empty)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
    logic [1:0] dr_exp [4] = '{2'd2, 2'd3, 2'd1, 2'd2};

    initial begin
        rst = 1'b0;
        decode_en = 1'b1;
        rd_set_en = 1'b0;
        req_stall = 1'b0;
        ch_valid = 4'b0101;
        ch_stall = '0;
        ch_addr = '0;
        resume_valid = 1'b0;
        resume_addr = '0;
        stalled_set = '0;
        stalled_tag = '0;
        #12;
        chk("rst_get", 32'(fp_if.ch_get), 0);
        chk("rst_empty", 32'(f_empty), 1);
        chk("rst_oval", 32'(f_ov), 0);
        chk("rst_idle", 32'(f_idle), 0);
        decode_en = 1'b0;
        ch_valid = '0;
        tick();
        rst = 1'b1;
        tick();

        // Fixed priority: ch0 beats ch2
        ch_valid = 4'b0101;
        ch_addr[0] = 16'h1111;
        ch_addr[2] = 16'h2222;
        decode_en = 1'b1;
        #1;
        chk("fp_get", 32'(fp_if.ch_get), 32'b0001);
        chk("rr_get_ch0", 32'(rr_if.ch_get), 32'b0001);
        tick();
        decode_en = 1'b0;
        ch_valid = '0;
        chk("push_nempty", 32'(f_empty), 0);
        rd_set_en = 1'b1;
        #1;
        chk("set_next", 32'(f_nxt), 32'h11);
        tick();
        rd_set_en = 1'b0;
        chk("pop_valid", 32'(f_ov), 1);
        chk("pop_ch", 32'(f_ch), 0);
        chk("pop_tag", 32'(f_tag), 32'h11);
        chk("pop_empty", 32'(f_empty), 1);

        // Round-robin vs fixed, then fill the queue
        ch_valid = 4'b1110;
        ch_addr[1] = 16'h0101;
        ch_addr[2] = 16'h0202;
        ch_addr[3] = 16'h0303;
        decode_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_seq", 32'(rr_if.ch_get), 32'(rr_exp[i]));
            chk("fp_seq", 32'(fp_if.ch_get), 32'b0010);
            tick();
        end
        chk("fp_full", 32'(f_full), 1);
        chk("rr_full", 32'(r_full), 1);
        #1;
        chk("full_fp_get", 32'(fp_if.ch_get), 0);
        chk("full_rr_get", 32'(rr_if.ch_get), 0);
        tick();
        chk("full_hold", 32'(r_full), 1);
        rd_set_en = 1'b1;
        #1;
        chk("pp_rr_get", 32'(rr_if.ch_get), 32'b0100);
        chk("pp_fp_get", 32'(fp_if.ch_get), 32'b0010);
        tick();
        decode_en = 1'b0;
        ch_valid = '0;
        chk("pp_out_ch", 32'(r_ch), 1);
        chk("pp_full", 32'(r_full), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_ch", 32'(r_ch), 32'(dr_exp[i]));
        end
        chk("drain_empty", 32'(r_empty), 1);
        tick();
        rd_set_en = 1'b0;
        chk("empty_pop_val", 32'(r_ov), 0);
        chk("empty_pop_ch", 32'(r_ch), 2);

        // Stalled-only request: nothing eligible
        ch_valid = 4'b0001;
        ch_stall = 4'b0001;
        decode_en = 1'b1;
        #1;
        chk("stall_get", 32'(fp_if.ch_get), 0);
        tick();
        chk("idle_set", 32'(f_idle), 1);
        ch_stall = '0;

        // Stall clear on RSP_CH pop with matching set/tag
        req_stall = 1'b1;
        stalled_set = 8'h12;
        stalled_tag = 8'h34;
        ch_addr[1] = 16'h3412;
        ch_addr[2] = 16'h3412;
        ch_valid = 4'b0010;
        tick();
        chk("idle_clr", 32'(f_idle), 0);
        ch_valid = 4'b0100;
        tick();
        ch_valid = '0;
        decode_en = 1'b0;
        rd_set_en = 1'b1;
        #1;
        chk("clr_fp", 32'(f_clr), 1);
        chk("clr_rr", 32'(r_clr), 1);
        tick();
        chk("clr_ch2", 32'(f_clr), 0);
        tick();
        rd_set_en = 1'b0;
        #1;
        chk("clr_idle", 32'(f_clr), 0);

        // Resume overrides every channel
        resume_valid = 1'b1;
        resume_addr = 16'hABCD;
        ch_valid = 4'b1111;
        decode_en = 1'b1;
        #1;
        chk("res_get", 32'(fp_if.resume_get), 1);
        chk("res_chget", 32'(fp_if.ch_get), 0);
        tick();
        resume_valid = 1'b0;
        ch_valid = '0;
        decode_en = 1'b0;
        rd_set_en = 1'b1;
        #1;
        chk("res_noclr", 32'(f_clr), 0);
        tick();
        rd_set_en = 1'b0;
        chk("res_flag", 32'(f_ir), 1);
        chk("res_tag", 32'(f_tag), 32'hAB);
        chk("res_set", 32'(f_set), 32'hCD);

        // Reset with entries queued
        ch_valid = 4'b0001;
        ch_addr[0] = 16'h5555;
        decode_en = 1'b1;
        repeat (3) tick();
        chk("pre_rst_ne", 32'(f_empty), 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_empty", 32'(f_empty), 1);
        chk("mid_rst_oval", 32'(f_ov), 0);
        chk("mid_rst_get", 32'(fp_if.ch_get), 0);
        decode_en = 1'b0;
        ch_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_empty", 32'(f_empty), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
